// File: rtl/rx_pol_pkg.sv
// rx_pol_pkg: FSM state encoding, default comma markers and counter sizing for rx_pol_track.
package rx_pol_pkg;

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_DET_PRE = 2'd1;
    localparam logic [1:0] ST_POL_GOT = 2'd2;
    localparam logic [1:0] ST_POL_CHK = 2'd3;

    localparam logic [9:0] DEF_COMMA_POS     = 10'b10_1011_1100;
    localparam logic [9:0] DEF_COMMA_NEG     = 10'b10_0100_0011;
    localparam logic [9:0] DEF_ORI_COMMA_POS = 10'b01_0111_1100;

    function automatic int cnt_width(input int det_num, input int chk_num);
        return $clog2((det_num > chk_num ? det_num : chk_num) + 1);
    endfunction

endpackage

// File: rtl/rx_pol_lane.sv
// rx_pol_lane: one lane's polarity FSM with hysteresis counter, inversion decision and marker-rewriting data register.
module rx_pol_lane
    import rx_pol_pkg::*;
#(
    parameter logic [9:0] COMMA_POS     = DEF_COMMA_POS,
    parameter logic [9:0] COMMA_NEG     = DEF_COMMA_NEG,
    parameter logic [9:0] ORI_COMMA_POS = DEF_ORI_COMMA_POS,
    parameter int         DET_NUM       = 16,
    parameter int         CHK_NUM       = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_cont_adj,
    input  logic       i_ow,
    input  logic       i_ow_val,
    input  logic       i_vld,
    input  logic [9:0] i_data,
    output logic       o_vld,
    output logic [9:0] o_data,
    output logic       o_pol_done,
    output logic       o_pol_status,
    output logic       o_relock
);

    localparam int            CW    = cnt_width(DET_NUM, CHK_NUM);
    localparam logic [CW-1:0] DET_C = CW'(DET_NUM);
    localparam logic [CW-1:0] CHK_C = CW'(CHK_NUM);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pol_q, pol_d;
    logic          vld_q;
    logic [9:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          relock_q, relock_d;

    logic pos_hit, neg_hit, match, unmatch, to_ori, to_inv_ori, inv;

    assign pos_hit    = (i_data == COMMA_POS) || (i_data == COMMA_NEG);
    assign neg_hit    = (i_data == ~COMMA_POS) || (i_data == ~COMMA_NEG);
    assign match      = pol_q ? neg_hit : pos_hit;
    assign unmatch    = pol_q ? pos_hit : neg_hit;
    assign to_ori     = (i_data == COMMA_POS) || (i_data == ~COMMA_POS);
    assign to_inv_ori = (i_data == COMMA_NEG) || (i_data == ~COMMA_NEG);
    // A disabled lane passes data straight through even while pol_q is being cleared.
    assign inv        = (i_en | i_ow) & pol_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pol_d    = pol_q;
        relock_d = 1'b0;
        if (i_ow) begin
            state_d = ST_INIT;
            cnt_d   = '0;
            pol_d   = i_ow_val;
        end else if (!i_en) begin
            state_d = ST_INIT;
            cnt_d   = '0;
            pol_d   = 1'b0;
        end else if (state_q == ST_INIT) begin
            state_d = ST_DET_PRE;
        end else if (i_vld) begin
            case (state_q)
                ST_DET_PRE: begin
                    if (unmatch) begin
                        pol_d = ~pol_q;
                        cnt_d = CW'(1);
                    end else if (match) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (cnt_d == DET_C) begin
                        state_d = ST_POL_GOT;
                        cnt_d   = '0;
                    end
                end
                ST_POL_GOT: begin
                    if (unmatch && i_cont_adj) begin
                        state_d = ST_POL_CHK;
                        cnt_d   = CW'(1);
                    end
                end
                default: begin
                    cnt_d = match ? cnt_q - 1'b1 : unmatch ? cnt_q + 1'b1 : cnt_q;
                    if (cnt_d == '0) begin
                        state_d = ST_POL_GOT;
                    end else if (cnt_d == CHK_C) begin
                        state_d  = ST_DET_PRE;
                        cnt_d    = '0;
                        relock_d = 1'b1;
                    end
                end
            endcase
        end
    end

    assign done_d = i_ow | (state_d == ST_POL_GOT) | (state_d == ST_POL_CHK);
    assign data_d = !i_vld ? data_q : to_ori ? ORI_COMMA_POS : to_inv_ori ? ~ORI_COMMA_POS : i_data ^ {10{inv}};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            pol_q    <= 1'b0;
            vld_q    <= 1'b0;
            data_q   <= ORI_COMMA_POS;
            done_q   <= 1'b0;
            relock_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pol_q    <= pol_d;
            vld_q    <= i_vld;
            data_q   <= data_d;
            done_q   <= done_d;
            relock_q <= relock_d;
        end
    end

    assign o_vld        = vld_q;
    assign o_data       = data_q;
    assign o_pol_done   = done_q;
    assign o_pol_status = pol_q;
    assign o_relock     = relock_q;

endmodule

// File: rtl/rx_pol_track.sv
// rx_pol_track: multi-lane RX polarity tracker; define RX_POL_STAT_EN to add per-lane saturating relock counters.
module rx_pol_track
    import rx_pol_pkg::*;
#(
    parameter int         NUM_LANES     = 4,
    parameter logic [9:0] COMMA_POS     = DEF_COMMA_POS,
    parameter logic [9:0] COMMA_NEG     = DEF_COMMA_NEG,
    parameter logic [9:0] ORI_COMMA_POS = DEF_ORI_COMMA_POS,
    parameter int         DET_NUM       = 16,
    parameter int         CHK_NUM       = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_LANES-1:0]    i_pol_adj_en,
    input  logic                    i_pol_cont_adj,
    input  logic [NUM_LANES-1:0]    i_pol_ow,
    input  logic [NUM_LANES-1:0]    i_pol_ow_val,
    input  logic [NUM_LANES-1:0]    i_vld,
    input  logic [10*NUM_LANES-1:0] i_data,
`ifdef RX_POL_STAT_EN
    input  logic                    i_stat_clr,
    output logic [8*NUM_LANES-1:0]  o_flip_cnt,
`endif
    output logic [NUM_LANES-1:0]    o_vld,
    output logic [10*NUM_LANES-1:0] o_data,
    output logic [NUM_LANES-1:0]    o_pol_done,
    output logic [NUM_LANES-1:0]    o_pol_status,
    output logic [NUM_LANES-1:0]    o_relock
);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        rx_pol_lane #(
            .COMMA_POS    (COMMA_POS),
            .COMMA_NEG    (COMMA_NEG),
            .ORI_COMMA_POS(ORI_COMMA_POS),
            .DET_NUM      (DET_NUM),
            .CHK_NUM      (CHK_NUM)
        ) u_lane (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_en        (i_pol_adj_en[k]),
            .i_cont_adj  (i_pol_cont_adj),
            .i_ow        (i_pol_ow[k]),
            .i_ow_val    (i_pol_ow_val[k]),
            .i_vld       (i_vld[k]),
            .i_data      (i_data[10*k +: 10]),
            .o_vld       (o_vld[k]),
            .o_data      (o_data[10*k +: 10]),
            .o_pol_done  (o_pol_done[k]),
            .o_pol_status(o_pol_status[k]),
            .o_relock    (o_relock[k])
        );
    end

`ifdef RX_POL_STAT_EN
    logic [7:0] flip_cnt_q [NUM_LANES];
    logic [7:0] flip_cnt_d [NUM_LANES];

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            flip_cnt_d[k] = i_stat_clr ? 8'd0 : (o_relock[k] && flip_cnt_q[k] != 8'hFF) ? flip_cnt_q[k] + 8'd1 : flip_cnt_q[k];
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            flip_cnt_q[k] <= i_rst ? 8'd0 : flip_cnt_d[k];
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_stat
        assign o_flip_cnt[8*k +: 8] = flip_cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_rx_pol_track.sv
// tb_rx_pol_track: scenario tasks drive symbols and queue the expected output words; each cycle drains the queue against o_data.
module tb_rx_pol_track;

    localparam int         NL  = 4;
    localparam logic [9:0] CP  = 10'h2BC;
    localparam logic [9:0] CN  = 10'h243;
    localparam logic [9:0] ORI = 10'h17C;

    typedef struct packed {
        int         lane;
        logic [9:0] d;
    } sb_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NL-1:0]   en = '0, ow = '0, ow_val = '0, vld = '0;
    logic            cont = 1'b0;
    logic [10*NL-1:0] din = '0;
    logic [NL-1:0]   o_vld, o_done, o_status, o_relock;
    logic [10*NL-1:0] o_data;
`ifdef RX_POL_STAT_EN
    logic            stat_clr = 1'b0;
    logic [8*NL-1:0] o_flip_cnt;
`endif

    sb_t sbq[$];
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    rx_pol_track #(.NUM_LANES(NL)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pol_adj_en  (en),
        .i_pol_cont_adj(cont),
        .i_pol_ow      (ow),
        .i_pol_ow_val  (ow_val),
        .i_vld         (vld),
        .i_data        (din),
`ifdef RX_POL_STAT_EN
        .i_stat_clr    (stat_clr),
        .o_flip_cnt    (o_flip_cnt),
`endif
        .o_vld         (o_vld),
        .o_data        (o_data),
        .o_pol_done    (o_done),
        .o_pol_status  (o_status),
        .o_relock      (o_relock)
    );

    task automatic tick();
        sb_t e;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NL; k++) begin
            if (o_vld[k]) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra lane%0d got %h with nothing expected", k, o_data[10*k +: 10]);
                end else begin
                    e = sbq.pop_front();
                    if (e.lane != k || o_data[10*k +: 10] !== e.d) begin
                        errors++;
                        $display("FAIL sb_data lane%0d got %h expected lane%0d %h", k, o_data[10*k +: 10], e.lane, e.d);
                    end
                end
            end
        end
    endtask

    task automatic send(input int ln, input logic [9:0] d, input logic [9:0] exp_d);
        vld[ln] = 1'b1;
        din[10*ln +: 10] = d;
        sbq.push_back('{ln, exp_d});
        tick();
        vld[ln] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 5;
        if (o_vld !== 4'h0) begin errors++; $display("FAIL rst_vld got %b expected 0", o_vld); end
        if (o_data !== {4{ORI}}) begin errors++; $display("FAIL rst_data got %h expected %h", o_data, {4{ORI}}); end
        if (o_done !== 4'h0) begin errors++; $display("FAIL rst_done got %b expected 0", o_done); end
        if (o_status !== 4'h0) begin errors++; $display("FAIL rst_status got %b expected 0", o_status); end
        if (o_relock !== 4'h0) begin errors++; $display("FAIL rst_relock got %b expected 0", o_relock); end
        rst = 1'b0;
    endtask

    task automatic test_lock_pos();
        en[0] = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            send(0, CP, ORI);
            if (i >= 14) begin
                checks++;
                if (o_done[0] !== (i == 15)) begin errors++; $display("FAIL lock0_done i=%0d got %b expected %b", i, o_done[0], i == 15); end
            end
        end
        checks++;
        if (o_status[0] !== 1'b0) begin errors++; $display("FAIL lock0_status got %b expected 0", o_status[0]); end
        send(0, 10'h2AA, 10'h2AA);
    endtask

    task automatic test_lock_neg();
        en[1] = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            send(1, ~CN, ~ORI);
            if (i == 0) begin
                checks++;
                if (o_status[1] !== 1'b1) begin errors++; $display("FAIL neg_flip got %b expected 1", o_status[1]); end
            end
        end
        checks += 2;
        if (o_done[1] !== 1'b1) begin errors++; $display("FAIL neg_done got %b expected 1", o_done[1]); end
        if (o_status[1] !== 1'b1) begin errors++; $display("FAIL neg_status got %b expected 1", o_status[1]); end
        send(1, 10'h2AA, 10'h155);
        send(1, 10'h0F0, 10'h30F);
    endtask

    task automatic test_relock();
        en[2] = 1'b1;
        cont = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(2, CP, ORI);
        checks++;
        if (o_done[2] !== 1'b1) begin errors++; $display("FAIL relock_pre_done got %b expected 1", o_done[2]); end
        for (int i = 0; i < 16; i++) begin
            send(2, ~CP, ORI);
            checks += 2;
            if (o_relock[2] !== (i == 15)) begin errors++; $display("FAIL relock_pulse i=%0d got %b expected %b", i, o_relock[2], i == 15); end
            if (o_done[2] !== (i != 15)) begin errors++; $display("FAIL relock_done i=%0d got %b expected %b", i, o_done[2], i != 15); end
            tick();
            checks++;
            if (o_relock[2] !== 1'b0) begin errors++; $display("FAIL relock_gap i=%0d got %b expected 0", i, o_relock[2]); end
        end
        checks++;
        if (o_status[2] !== 1'b0) begin errors++; $display("FAIL relock_status got %b expected 0", o_status[2]); end
        send(2, ~CP, ORI);
        checks++;
        if (o_status[2] !== 1'b1) begin errors++; $display("FAIL relock_detpre got %b expected 1", o_status[2]); end
    endtask

    task automatic test_hysteresis();
        logic seen;
        logic done_all;
        en[3] = 1'b1;
        cont = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send(3, CP, ORI);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin send(3, ~CN, ~ORI); seen |= o_relock[3]; end
        for (int i = 0; i < 3; i++) begin send(3, CP, ORI); seen |= o_relock[3]; end
        for (int i = 0; i < 15; i++) begin send(3, ~CN, ~ORI); seen |= o_relock[3]; end
        checks += 2;
        if (seen !== 1'b0) begin errors++; $display("FAIL hyst_norelock got %b expected 0", seen); end
        if (o_done[3] !== 1'b1) begin errors++; $display("FAIL hyst_done got %b expected 1", o_done[3]); end
        send(3, ~CN, ~ORI);
        checks++;
        if (o_relock[3] !== 1'b1) begin errors++; $display("FAIL hyst_relock got %b expected 1", o_relock[3]); end
        tick();
        cont = 1'b0;
        for (int i = 0; i < 16; i++) send(3, CP, ORI);
        seen = 1'b0;
        done_all = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(3, ~CN, ~ORI);
            seen |= o_relock[3];
            done_all &= o_done[3];
        end
        checks += 3;
        if (seen !== 1'b0) begin errors++; $display("FAIL once_relock got %b expected 0", seen); end
        if (done_all !== 1'b1) begin errors++; $display("FAIL once_done got %b expected 1", done_all); end
        if (o_status[3] !== 1'b0) begin errors++; $display("FAIL once_status got %b expected 0", o_status[3]); end
        cont = 1'b1;
    endtask

    task automatic test_override();
        en[0] = 1'b0;
        tick();
        checks++;
        if (o_done[0] !== 1'b0) begin errors++; $display("FAIL ow_dis_done got %b expected 0", o_done[0]); end
        en[0] = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send(0, CP, ORI);
        ow[0] = 1'b1;
        ow_val[0] = 1'b1;
        tick();
        checks += 2;
        if (o_status[0] !== 1'b1) begin errors++; $display("FAIL ow_status got %b expected 1", o_status[0]); end
        if (o_done[0] !== 1'b1) begin errors++; $display("FAIL ow_done got %b expected 1", o_done[0]); end
        send(0, 10'h2AA, 10'h155);
        send(0, CP, ORI);
        en[0] = 1'b0;
        tick();
        checks += 2;
        if (o_status[0] !== 1'b1) begin errors++; $display("FAIL ow_en_status got %b expected 1", o_status[0]); end
        if (o_done[0] !== 1'b1) begin errors++; $display("FAIL ow_en_done got %b expected 1", o_done[0]); end
        ow[0] = 1'b0;
        tick();
        checks += 2;
        if (o_status[0] !== 1'b0) begin errors++; $display("FAIL dis_status got %b expected 0", o_status[0]); end
        if (o_done[0] !== 1'b0) begin errors++; $display("FAIL dis_done got %b expected 0", o_done[0]); end
        send(0, 10'h2AA, 10'h2AA);
        send(0, ~CN, ~ORI);
    endtask

    task automatic test_hold();
        tick();
        checks += 2;
        if (o_vld[0] !== 1'b0) begin errors++; $display("FAIL hold_vld got %b expected 0", o_vld[0]); end
        if (o_data[9:0] !== ~ORI) begin errors++; $display("FAIL hold_data got %h expected %h", o_data[9:0], ~ORI); end
    endtask

    task automatic test_reset_locked();
        vld[1] = 1'b1;
        din[19:10] = CP;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vld[1] = 1'b0;
        checks += 5;
        if (o_vld !== 4'h0) begin errors++; $display("FAIL rstl_vld got %b expected 0", o_vld); end
        if (o_data !== {4{ORI}}) begin errors++; $display("FAIL rstl_data got %h expected %h", o_data, {4{ORI}}); end
        if (o_done !== 4'h0) begin errors++; $display("FAIL rstl_done got %b expected 0", o_done); end
        if (o_status !== 4'h0) begin errors++; $display("FAIL rstl_status got %b expected 0", o_status); end
        if (o_relock !== 4'h0) begin errors++; $display("FAIL rstl_relock got %b expected 0", o_relock); end
    endtask

`ifdef RX_POL_STAT_EN
    task automatic test_stat();
        en[2] = 1'b1;
        cont = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) send(2, CP, ORI);
            for (int i = 0; i < 16; i++) send(2, ~CP, ORI);
        end
        tick();
        tick();
        checks++;
        if (o_flip_cnt[23:16] !== 8'd3) begin errors++; $display("FAIL stat_cnt got %0d expected 3", o_flip_cnt[23:16]); end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        checks++;
        if (o_flip_cnt[23:16] !== 8'd0) begin errors++; $display("FAIL stat_clr got %0d expected 0", o_flip_cnt[23:16]); end
    endtask
`endif

    initial begin
        test_reset();
        test_lock_pos();
        test_lock_neg();
        test_relock();
        test_hysteresis();
        test_override();
        test_hold();
        test_reset_locked();
`ifdef RX_POL_STAT_EN
        test_stat();
`endif
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL sb_left got %0d pending expected 0", sbq.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_pol_track.md
Name: rx_pol_track

Overview:
- Multi-lane, parametrised successor of the single-lane 10b RX polarity adjuster.
- Sits between the deserialiser and the 10b/8b decoder.
- Per lane: detects the polarity-marker commas, locks a per-lane inversion decision with hysteresis, inverts data when needed, and rewrites the marker commas back to standard K28.5+/-.
- Adds a per-lane valid qualifier, per-lane override, configurable thresholds, and relock/status reporting.

Parameters:
NUM_LANES, 4, number of independent 10b lanes
COMMA_POS, 10'b10_1011_1100, positive polarity marker (K28.2+)
COMMA_NEG, 10'b10_0100_0011, negative polarity marker (K28.6-)
ORI_COMMA_POS, 10'b01_0111_1100, standard comma substituted for markers (K28.5+)
DET_NUM, 16, consecutive same-polarity markers needed to declare lock (2..255)
CHK_NUM, 16, net reversed-marker excess that drops lock back to detection (2..255)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_pol_adj_en  in  NUM_LANES  per-lane enable of polarity tracking
i_pol_cont_adj  in  1  0: lock once, never recheck; 1: continuous checking
i_pol_ow  in  NUM_LANES  per-lane polarity override
i_pol_ow_val  in  NUM_LANES  override value (1 = invert)
i_vld  in  NUM_LANES  per-lane input symbol valid
i_data  in  10*NUM_LANES  lane k at [10k+9:10k]
o_vld  out  NUM_LANES  registered i_vld
o_data  out  10*NUM_LANES  adjusted data
o_pol_done  out  NUM_LANES  lane locked (POL_GOT/POL_CHK) or overridden
o_pol_status  out  NUM_LANES  current inversion decision
o_relock  out  NUM_LANES  one-cycle pulse when a lane falls POL_CHK -> DET_PRE

Behaviour:
- Reset (i_rst=1 at posedge): o_vld=0, o_data=ORI_COMMA_POS per lane, o_pol_done=0, o_pol_status=0, o_relock=0, state INIT, cnt=0.
- Lanes are fully independent; all lane logic advances only on cycles where that lane's i_vld=1, except for reset, enable-low and override.
- Hit decode: pos_hit = data is COMMA_POS or COMMA_NEG; neg_hit = data is ~COMMA_POS or ~COMMA_NEG.
  - match = hit agreeing with cur_pol (pos_hit with cur_pol=0, neg_hit with cur_pol=1).
  - unmatch = the opposite case.
- Counter width: clog2(max(DET_NUM,CHK_NUM)+1) bits.
- FSM per lane:
  - INIT: enable=1 -> DET_PRE.
  - DET_PRE:
    - match: cnt+1.
    - unmatch: cur_pol flips to the observed polarity, cnt=1.
    - Once cnt reaches DET_NUM: -> POL_GOT, cnt=0.
  - POL_GOT: unmatch with i_pol_cont_adj=1 -> POL_CHK, cnt=1; otherwise stay. cur_pol is frozen.
  - POL_CHK:
    - match: cnt-1; unmatch: cnt+1.
    - cnt reaches 0: -> POL_GOT.
    - cnt reaches CHK_NUM: -> DET_PRE, cnt=0, o_relock pulses next cycle, cur_pol unchanged.
- i_pol_adj_en[k]=0: state forced to INIT, cnt=0, cur_pol=0 next cycle. Data passes uninverted, with comma replacement only.
- i_pol_ow[k]=1:
  - cur_pol=i_pol_ow_val, state held INIT, o_pol_done=1.
  - Overrides the enable; takes precedence over all FSM updates.
- Data path, registered, 1-cycle latency:
  - COMMA_POS or ~COMMA_POS -> ORI_COMMA_POS.
  - COMMA_NEG or ~COMMA_NEG -> ~ORI_COMMA_POS.
  - Otherwise: data ^ {10{cur_pol}}, using the registered cur_pol before that cycle's update.
- i_vld=0: o_data holds its previous value; o_vld=0.
- o_pol_status = cur_pol register.
- o_pol_done, o_relock are registered; no combinational input-to-output paths.

Optional Feature:
- Macro RX_POL_STAT_EN. When defined, adds:
  - Output o_flip_cnt, 8*NUM_LANES: per-lane saturating count of o_relock events.
  - Input i_stat_clr, 1: synchronous clear, priority over increment.
- When undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package rx_pol_pkg holds:
  - state encoding (INIT=0, DET_PRE=1, POL_GOT=2, POL_CHK=3);
  - default comma constants;
  - a function computing counter width.
- Sub-module rx_pol_lane: one lane's FSM, counter, cur_pol and data register.
- rx_pol_track is the generate loop plus the optional stat counters.

Test Plan:
- Reset, enable lane0, 16 valid COMMA_POS symbols -> o_pol_done[0]=1 after the 16th plus 1 cycle, o_pol_status[0]=0; o_data shows 10'h17C for each marker.
- Lane1 fed 16 ~COMMA_NEG -> o_pol_status[1]=1; data 10'h2AA then outputs 10'h155; ~COMMA_NEG outputs ~ORI_COMMA_POS.
- Locked lane2, cont_adj=1, 16 reversed markers with i_vld gaps -> o_relock[2] single pulse, state DET_PRE, o_pol_done[2]=0.
- Locked lane3, cont_adj=1: 3 reversed markers, then 3 matching -> returns to POL_GOT, no relock. Same with cont_adj=0 -> remains POL_GOT throughout.
- i_pol_ow[0]=1, val=1 mid-detection -> next cycle o_pol_status[0]=1, o_pol_done[0]=1, data inverted. Deassert enable -> INIT, status 0.
- i_rst asserted while locked -> all outputs at reset values next cycle. With RX_POL_STAT_EN: 3 relocks -> o_flip_cnt=3; i_stat_clr -> 0.
